// File: rtl/q_issue_queue.sv
// Issue queue: buffers tagged quantum instructions and releases them on a
// delay-driven schedule, issuing VLIW bundles atomically on consecutive cycles.
module q_issue_queue #(
  parameter int DATA_W     = 64,
  parameter int DEPTH      = 16,
  parameter int TS_W       = 32,
  parameter int MAX_BUNDLE = 4,
  parameter int BL_W       = $clog2(MAX_BUNDLE + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_inst,
  input  logic [TS_W-1:0]            in_delay,
  input  logic [BL_W-1:0]            in_blen,
  input  logic                       stop_req,
  output logic [DATA_W-1:0]          q_inst,
  output logic                       q_inst_valid,
  output logic                       q_vliw,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       busy,
  output logic                       late_err,
  output logic                       done
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [BL_W-1:0]  MAX_BL   = BL_W'(MAX_BUNDLE);

  if ((DEPTH < MAX_BUNDLE) || (DEPTH < 2)) begin : g_paramCheck
    $error("q_issue_queue: DEPTH must be >= MAX_BUNDLE and >= 2");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ISSUE} state_t;

  logic [DATA_W-1:0] r_memInst  [DEPTH];
  logic [TS_W-1:0]   r_memDelay [DEPTH];
  logic [BL_W-1:0]   r_memBlen  [DEPTH];

  logic [PTR_W-1:0]  r_wrPtr, r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  state_t            r_state, w_stateNext;
  logic [TS_W-1:0]   r_waitCnt, w_waitNext;
  logic [BL_W-1:0]   r_bundleRem, w_remNext;
  logic              r_multi, w_multiNext;
  logic              w_setLate;
  logic [DATA_W-1:0] r_qInst;
  logic              r_qValid, r_qVliw, r_lateErr, r_done, r_stopLatched;

  logic              w_push, w_pop;
  logic [PTR_W-1:0]  w_rdNext;
  logic [BL_W-1:0]   w_headEblen;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // A zero length still means a single word; oversized lengths are clamped.
  function automatic logic [BL_W-1:0] effLen(input logic [BL_W-1:0] bl);
    if (bl == '0)
      return BL_W'(1);
    else if (bl > MAX_BL)
      return MAX_BL;
    else
      return bl;
  endfunction

  assign in_ready    = (r_count < DEPTH_C) & ~r_stopLatched & ~r_done;
  assign w_push      = in_valid & in_ready & ~flush;
  assign w_pop       = (r_state == ST_ISSUE) & ~flush;
  assign w_rdNext    = nextPtr(r_rdPtr);
  assign w_headEblen = effLen(r_memBlen[r_rdPtr]);

  always_comb begin
    w_stateNext = r_state;
    w_waitNext  = r_waitCnt;
    w_remNext   = r_bundleRem;
    w_multiNext = r_multi;
    w_setLate   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_count != '0) begin
          w_waitNext  = r_memDelay[r_rdPtr];
          w_stateNext = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_waitCnt != '0) begin
          w_waitNext = r_waitCnt - TS_W'(1);
        end else if (r_count >= CNT_W'(w_headEblen)) begin
          w_remNext   = w_headEblen;
          w_multiNext = (w_headEblen > BL_W'(1));
          w_stateNext = ST_ISSUE;
        end else begin
          w_setLate = 1'b1;
        end
      end
      ST_ISSUE: begin
        w_remNext = r_bundleRem - BL_W'(1);
        // A word pushed during the final pop is picked up via IDLE next cycle.
        if (r_bundleRem == BL_W'(1)) begin
          if (r_count > CNT_W'(1)) begin
            w_waitNext  = r_memDelay[w_rdNext];
            w_stateNext = ST_WAIT;
          end else begin
            w_stateNext = ST_IDLE;
          end
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
    if (flush) begin
      w_stateNext = ST_IDLE;
      w_waitNext  = '0;
      w_remNext   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_memInst[r_wrPtr]  <= in_inst;
      r_memDelay[r_wrPtr] <= in_delay;
      r_memBlen[r_wrPtr]  <= in_blen;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_waitCnt     <= '0;
      r_bundleRem   <= '0;
      r_multi       <= 1'b0;
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
      r_count       <= '0;
      r_qInst       <= '0;
      r_qValid      <= 1'b0;
      r_qVliw       <= 1'b0;
      r_lateErr     <= 1'b0;
      r_done        <= 1'b0;
      r_stopLatched <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_waitCnt   <= w_waitNext;
      r_bundleRem <= w_remNext;
      r_multi     <= w_multiNext;
      if (flush) begin
        r_wrPtr <= '0;
        r_rdPtr <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wrPtr <= nextPtr(r_wrPtr);
        if (w_pop)  r_rdPtr <= w_rdNext;
        if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
        else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
      end
      r_qValid <= w_pop;
      r_qVliw  <= w_pop & r_multi;
      if (w_pop) r_qInst <= r_memInst[r_rdPtr];
      if (flush)          r_lateErr <= 1'b0;
      else if (w_setLate) r_lateErr <= 1'b1;
      if (stop_req) r_stopLatched <= 1'b1;
      // Done is sticky until reset so the controller cannot miss the drain.
      if (r_stopLatched && (r_state == ST_IDLE) && (r_count == '0)) r_done <= 1'b1;
    end
  end

  assign q_inst       = r_qInst;
  assign q_inst_valid = r_qValid;
  assign q_vliw       = r_qVliw;
  assign fifo_count   = r_count;
  assign busy         = (r_state != ST_IDLE) | (r_count != '0);
  assign late_err     = r_lateErr;
  assign done         = r_done;

endmodule

// File: tb/tb_q_issue_queue.sv
// Scoreboard bench for q_issue_queue: a schedule-level model predicts issue
// cycles per bundle; a negedge monitor compares every issued word.
module tb_q_issue_queue;
  localparam int DATA_W = 64;
  localparam int DEPTH = 16;
  localparam int TS_W = 32;
  localparam int MAX_BUNDLE = 4;
  localparam int BL_W = 3;
  localparam int CNT_W = 5;

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, in_ready, stop_req;
  logic [DATA_W-1:0] in_inst, q_inst;
  logic [TS_W-1:0] in_delay;
  logic [BL_W-1:0] in_blen;
  logic q_inst_valid, q_vliw, busy, late_err, done;
  logic [CNT_W-1:0] fifo_count;

  always #5 clk = ~clk;

  q_issue_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W), .MAX_BUNDLE(MAX_BUNDLE)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_delay(in_delay), .in_blen(in_blen), .stop_req(stop_req),
    .q_inst(q_inst), .q_inst_valid(q_inst_valid), .q_vliw(q_vliw), .fifo_count(fifo_count),
    .busy(busy), .late_err(late_err), .done(done)
  );

  typedef struct {
    logic [63:0] data;
    int          cycle;
    logic        vliw;
  } exp_t;

  exp_t expQ[$];
  int obsCyc[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int lastFree = 0;
  int lateFirst = -1;
  logic modelLate = 1'b0;
  exp_t monItem;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every issued word must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (late_err && lateFirst < 0) lateFirst = cyc;
      if (q_inst_valid) begin
        obsCyc.push_back(cyc);
        if (expQ.size() == 0) begin
          checkOutput("unexpected_issue", 64'd1, 64'd0);
        end else begin
          monItem = expQ.pop_front();
          checkOutput("issue_data", q_inst, monItem.data);
          checkOutput("issue_cycle", 64'(cyc), 64'(monItem.cycle));
          checkOutput("issue_vliw", {63'd0, q_vliw}, {63'd0, monItem.vliw});
        end
      end
    end
  end

  task automatic applyStimulus(input logic [63:0] data, input int d, input int bl, output int p);
    int guard = 0;
    while (!in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) checkOutput("push_ready_timeout", 64'd0, 64'd1);
    in_valid = 1'b1;
    in_inst  = data;
    in_delay = TS_W'(d);
    in_blen  = BL_W'(bl);
    p = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Model: a group starts waiting either right after the previous group (if its
  // head was already queued) or two cycles after its head arrives; it issues once
  // its delay has elapsed and all of its words are present.
  task automatic sendGroup(input logic [63:0] words[4], input int gaps[4], input int d,
                           input int bl, output int pHead);
    int e, p, pLast, tw, iss, tmp;
    exp_t item;
    e = (bl == 0) ? 1 : ((bl > MAX_BUNDLE) ? MAX_BUNDLE : bl);
    pLast = 0;
    pHead = 0;
    for (int i = 0; i < e; i++) begin
      repeat (gaps[i]) @(negedge clk);
      if (i == 0) applyStimulus(words[i], d, bl, p);
      else applyStimulus(words[i], int'($urandom_range(0, 50)), int'($urandom_range(0, 7)), p);
      if (i == 0) pHead = p;
      pLast = p;
    end
    if (pHead <= lastFree - 2) tw = lastFree;
    else begin
      tmp = (pHead + 1 > lastFree) ? pHead + 1 : lastFree;
      tw = tmp + 1;
    end
    if (pLast + 1 > tw + d) modelLate = 1'b1;
    iss = ((tw + d > pLast + 1) ? tw + d : pLast + 1) + 1;
    for (int i = 0; i < e; i++) begin
      item.data  = words[i];
      item.cycle = iss + 1 + i;
      item.vliw  = (e > 1);
      expQ.push_back(item);
    end
    lastFree = iss + e;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    stop_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expQ.delete();
    obsCyc.delete();
    lastFree = cyc;
    modelLate = 1'b0;
    lateFirst = -1;
  endtask

  task automatic waitDrain(input int bound);
    int n = 0;
    while ((busy || expQ.size() != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_in_time", {63'd0, (n < bound)}, 64'd1);
    @(negedge clk);
  endtask

  logic [63:0] w[4];
  int g[4];
  int b, n;

  initial begin
    in_inst = '0;
    in_delay = '0;
    in_blen = '0;
    doReset();
    checkOutput("reset_valid", {63'd0, q_inst_valid}, 64'd0);
    checkOutput("reset_vliw", {63'd0, q_vliw}, 64'd0);
    checkOutput("reset_qinst", q_inst, 64'd0);
    checkOutput("reset_late", {63'd0, late_err}, 64'd0);
    checkOutput("reset_done", {63'd0, done}, 64'd0);
    checkOutput("reset_count", 64'(fifo_count), 64'd0);
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_ready", {63'd0, in_ready}, 64'd1);

    // Single word, delay 3: issues at push+7.
    g = '{0, 0, 0, 0};
    w = '{64'hA5, 64'h0, 64'h0, 64'h0};
    sendGroup(w, g, 3, 1, b);
    waitDrain(100);
    checkOutput("t1_count", 64'(obsCyc.size()), 64'd1);
    if (obsCyc.size() > 0) checkOutput("t1_cycle", 64'(obsCyc[0]), 64'(b + 7));
    checkOutput("t1_late", {63'd0, late_err}, 64'd0);
    checkOutput("t1_hold", q_inst, 64'hA5);

    // Two consecutive entries: issue at +4 and +7.
    doReset();
    w = '{64'h1, 64'h0, 64'h0, 64'h0};
    sendGroup(w, g, 0, 1, b);
    w = '{64'h2, 64'h0, 64'h0, 64'h0};
    sendGroup(w, g, 1, 1, n);
    waitDrain(100);
    checkOutput("t2_count", 64'(obsCyc.size()), 64'd2);
    if (obsCyc.size() > 1) begin
      checkOutput("t2_cycle0", 64'(obsCyc[0]), 64'(b + 4));
      checkOutput("t2_cycle1", 64'(obsCyc[1]), 64'(b + 7));
    end

    // Late bundle: words arrive after the delay expires.
    doReset();
    w = '{64'h31, 64'h32, 64'h33, 64'h0};
    g = '{0, 4, 0, 0};
    sendGroup(w, g, 0, 3, b);
    checkOutput("t3_late_set", {63'd0, late_err}, 64'd1);
    waitDrain(100);
    checkOutput("t3_late_from", 64'(lateFirst), 64'(b + 3));
    checkOutput("t3_count", 64'(obsCyc.size()), 64'd3);
    for (int i = 0; i < 3 && i < obsCyc.size(); i++)
      checkOutput("t3_cycle", 64'(obsCyc[i]), 64'(b + 9 + i));

    // Fill the FIFO; an extra push is refused until the first issue.
    doReset();
    g = '{0, 0, 0, 0};
    for (int i = 0; i < DEPTH; i++) begin
      w = '{64'(100 + i), 64'h0, 64'h0, 64'h0};
      sendGroup(w, g, 100, 1, n);
      if (i == 0) b = n;
    end
    checkOutput("t4_full_count", 64'(fifo_count), 64'(DEPTH));
    checkOutput("t4_full_ready", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b1;
    in_inst = 64'hDEAD;
    in_delay = '0;
    in_blen = 3'd1;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("t4_extra_count", 64'(fifo_count), 64'(DEPTH));
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t4_ready_cycle", 64'(cyc), 64'(b + 104));
    checkOutput("t4_after_pop", 64'(fifo_count), 64'(DEPTH - 1));
    waitDrain(3000);

    // Flush during the second word of a 4-word bundle.
    doReset();
    w = '{64'h41, 64'h42, 64'h43, 64'h44};
    sendGroup(w, g, 0, 4, b);
    checkOutput("t5_late_before", {63'd0, late_err}, 64'd1);
    n = 0;
    while (!q_inst_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    expQ.delete();
    checkOutput("t5_valid", {63'd0, q_inst_valid}, 64'd0);
    checkOutput("t5_count", 64'(fifo_count), 64'd0);
    checkOutput("t5_busy", {63'd0, busy}, 64'd0);
    checkOutput("t5_late", {63'd0, late_err}, 64'd0);
    repeat (8) @(negedge clk);
    checkOutput("t5_issued", 64'(obsCyc.size()), 64'd1);

    // Stop with two entries queued, then drain and done.
    doReset();
    w = '{64'h51, 64'h0, 64'h0, 64'h0};
    sendGroup(w, g, 1, 1, b);
    w = '{64'h52, 64'h0, 64'h0, 64'h0};
    sendGroup(w, g, 2, 1, n);
    stop_req = 1'b1;
    @(negedge clk);
    stop_req = 1'b0;
    checkOutput("t6_ready", {63'd0, in_ready}, 64'd0);
    n = 0;
    while (!(q_inst_valid && q_inst == 64'h52) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t6_done_early", {63'd0, done}, 64'd0);
    @(negedge clk);
    checkOutput("t6_done", {63'd0, done}, 64'd1);
    checkOutput("t6_issued", 64'(obsCyc.size()), 64'd2);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("t6_done_flush", {63'd0, done}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("t6_done_reset", {63'd0, done}, 64'd0);

    // Randomized groups with random gaps, delays and lengths.
    doReset();
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < 4; i++) begin
        w[i] = {$urandom, $urandom};
        g[i] = (i == 0) ? int'($urandom_range(0, 8)) : int'($urandom_range(0, 3));
      end
      sendGroup(w, g, int'($urandom_range(0, 6)), int'($urandom_range(0, 7)), n);
    end
    waitDrain(2000);
    checkOutput("rand_late", {63'd0, late_err}, {63'd0, modelLate});
    checkOutput("rand_count", 64'(fifo_count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/q_issue_queue.md
Name: q_issue_queue

Overview:
Parametrised successor to the fixed two-word VLIW issue logic of the classical controller. It buffers quantum instructions issued by the classical controller in a FIFO, each tagged with a relative issue delay and a bundle length. It releases them to the quantum interface on a precise cycle schedule, issuing VLIW bundles of up to MAX_BUNDLE words atomically on consecutive cycles. It sits between the classical controller's q_inst path and the quantum pulse/measurement back end, and provides drain-then-done stop semantics.

Parameters:
DATA_W, 64, instruction word width
DEPTH, 16, FIFO entries; must be >= MAX_BUNDLE and >= 2 (elaboration-time check)
TS_W, 32, delay field width
MAX_BUNDLE, 4, maximum VLIW bundle length
BL_W, $clog2(MAX_BUNDLE+1), bundle-length field width (derived)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
flush  in  1  synchronous clear of queue and sequencer
in_valid  in  1  push request
in_ready  out  1  push accepted when in_valid & in_ready
in_inst  in  DATA_W  instruction word
in_delay  in  TS_W  wait cycles before this entry issues
in_blen  in  BL_W  bundle length; only meaningful on the first word of a bundle
stop_req  in  1  pulse: stop accepting and drain
q_inst  out  DATA_W  issued instruction, registered
q_inst_valid  out  1  q_inst valid this cycle
q_vliw  out  1  high on every word of a bundle with length > 1
fifo_count  out  $clog2(DEPTH+1)  current occupancy
busy  out  1  state != IDLE or fifo_count != 0
late_err  out  1  sticky: the delay expired before the bundle was complete
done  out  1  sticky: stop latched and queue fully drained

Behaviour:
- Reset (rst_n=0 at an edge):
  - Pointers, count, wait_cnt, bundle_rem, and stop latch all clear.
  - State goes to IDLE.
  - q_inst=0, q_inst_valid=0, q_vliw=0, late_err=0, done=0.
- Push:
  - in_ready = (fifo_count < DEPTH) & ~stop_latched & ~done.
  - An accepted push writes {inst, delay, blen} at the tail.
  - There is no same-cycle bypass, so the entry is visible to the sequencer the next cycle.
  - Push and pop in the same cycle is legal; count is unchanged.
- Effective bundle length: eblen = 1 if blen == 0, MAX_BUNDLE if blen > MAX_BUNDLE, otherwise blen.
- Sequencer states: IDLE, WAIT, ISSUE.
  - IDLE, fifo_count > 0: load wait_cnt = head.delay, go to WAIT.
  - WAIT, wait_cnt != 0: decrement wait_cnt.
  - WAIT, wait_cnt == 0, fifo_count >= eblen(head): load bundle_rem = eblen, go to ISSUE.
  - WAIT, wait_cnt == 0, fifo_count < eblen(head): stay in WAIT and set late_err. The bundle issues once complete.
  - ISSUE: pop the head each cycle, register q_inst=head.inst, q_inst_valid=1, q_vliw=(eblen > 1), and decrement bundle_rem.
    - Delay/blen fields of non-first bundle words are ignored.
    - On the last word, if words remain after the pop: load wait_cnt from the new head's delay and go to WAIT.
    - On the last word, if the queue is empty after the pop: go to IDLE.
  - Outside ISSUE, q_inst_valid=0 and q_vliw=0; q_inst holds its last value.
- Timing:
  - Push at cycle 0 into an empty idle queue with delay d: q_inst_valid is high at cycle d+4.
  - Between the last word of one issue group and the first word of the next, the output spacing is d+2 cycles.
  - Words within a bundle are issued back-to-back with no gaps.
- Stop:
  - stop_req sets stop_latched.
  - done is set when stop_latched & state == IDLE & fifo_count == 0, and holds until reset.
  - Only reset clears done; flush does not.
- Flush:
  - Empties the FIFO, sets state to IDLE, clears wait_cnt and bundle_rem, drives q_inst_valid=0 next cycle, and clears late_err.
  - A flush in ISSUE aborts the remaining bundle words.
  - Flush beats a simultaneous push; the push is dropped.
  - Flush does not clear stop_latched.
- Pointers wrap modulo DEPTH; DEPTH need not be a power of two.
- Delay arithmetic is unsigned TS_W; there is no saturation issue because the counter only counts down.

Test Plan:
- Reset, then push inst=64'hA5, delay=3, blen=1 at cycle 0 -> q_inst_valid=1 with q_inst=64'hA5 only at cycle 7, q_vliw=0, late_err=0.
- Push 64'h1 (d=0) at cycle 0 and 64'h2 (d=1) at cycle 1 -> valid at cycle 4 (64'h1) and cycle 7 (64'h2).
- Push bundle head blen=3 d=0 at cycle 0, then words at cycles 5 and 6 -> late_err=1 from cycle 3; q_inst_valid and q_vliw high at cycles 9, 10, 11 in push order.
- Push 16 entries with d=100 -> fifo_count=16, in_ready=0; a 17th push attempt changes nothing; issue of the first entry restores in_ready.
- Flush at the second word of a 4-word bundle -> no further q_inst_valid, fifo_count=0, state IDLE, late_err=0.
- Two entries queued, then stop_req -> in_ready=0, both issue, done=1 the cycle after drain; flush keeps done=1; rst_n=0 clears it.
